// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the binary-to-BCD converter.
//   estado_t   : converter FSM states
//   nibble_t   : one BCD digit
//   ANCHO_DEF / DIGITOS_DEF : default binary width and digit count
//   BLANCO_RST : blank-flag reset pattern (all digits blanked except units)
//   cabe()     : true when DIGITOS digits can hold every ANCHO-bit value
package bcd_pkg;
    typedef enum logic [1:0] {REPOSO, DESPLAZA, FIN} estado_t;
    typedef logic [3:0] nibble_t;
    localparam int ANCHO_DEF = 8;
    localparam int DIGITOS_DEF = 3;
    localparam logic [31:0] BLANCO_RST = 32'hFFFF_FFFE;
    function automatic bit cabe(input int ancho, input int digitos);
        longint p10;
        p10 = 1;
        for (int i = 0; i < digitos; i++) p10 = p10 * 10;
        return p10 > ((longint'(1) << ancho) - 1);
    endfunction
endpackage

// File: rtl/suma3_bcd.sv
// suma3_bcd: combinational shift-and-add-3 cell, adds 3 when the digit is 5 or more.
//   entrada : BCD digit before correction
//   salida  : corrected digit, ready to be shifted left
module suma3_bcd
    import bcd_pkg::*;
(
    input  nibble_t entrada,
    output nibble_t salida
);
    assign salida = (entrada >= 4'd5) ? entrada + 4'd3 : entrada;
endmodule

// File: rtl/binario_a_bcd.sv
// binario_a_bcd: sequential binary-to-BCD converter with leading-zero blank flags.
//   Reloj, Reinicio_n      : clock, synchronous active-low reset
//   Dato, Dato_valido      : binary value and conversion request
//   Listo                  : idle, a request is accepted when Dato_valido && Listo
//   Bcd, Blanco            : packed BCD digits (units in [3:0]) and blank flags
//   Bcd_valido             : one-cycle pulse when Bcd/Blanco were just updated
module binario_a_bcd
    import bcd_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int DIGITOS = DIGITOS_DEF
) (
    input  logic                   Reloj,
    input  logic                   Reinicio_n,
    input  logic [ANCHO-1:0]       Dato,
    input  logic                   Dato_valido,
    output logic                   Listo,
    output logic [4*DIGITOS-1:0]   Bcd,
    output logic [DIGITOS-1:0]     Blanco,
    output logic                   Bcd_valido
);
    localparam int NB = 4 * DIGITOS;
    localparam int CW = $clog2(ANCHO + 1);
    localparam logic [DIGITOS-1:0] BLANCO_INI = BLANCO_RST[DIGITOS-1:0];

    if (!cabe(ANCHO, DIGITOS)) begin : g_digitos_insuficientes
        $error("binario_a_bcd: DIGITOS too small for ANCHO");
    end

    estado_t              estado, siguiente;
    logic [NB+ANCHO-1:0]  reg_d;
    logic [CW-1:0]        cuenta;
    logic [NB-1:0]        ajustado;
    logic [DIGITOS-1:0]   blanco_n;
    logic                 ceros;
    logic                 ultimo;

    for (genvar d = 0; d < DIGITOS; d++) begin : g_suma3
        suma3_bcd u_suma3 (
            .entrada(reg_d[ANCHO+4*d +: 4]),
            .salida (ajustado[4*d +: 4])
        );
    end

    assign ultimo = cuenta == CW'(ANCHO - 1);

    always_ff @(posedge Reloj) begin
        if (!Reinicio_n) estado <= REPOSO;
        else             estado <= siguiente;
    end

    always_comb begin
        siguiente = (estado == REPOSO)   ? (Dato_valido ? DESPLAZA : REPOSO) :
                    (estado == DESPLAZA) ? (ultimo ? FIN : DESPLAZA) : REPOSO;
    end

    always_comb begin
        Listo = estado == REPOSO;
    end

    // A digit is blanked only when it and every digit above it are zero.
    always_comb begin
        blanco_n = '0;
        ceros = 1'b1;
        for (int i = DIGITOS - 1; i >= 1; i--) begin
            ceros = ceros && (reg_d[ANCHO+4*i +: 4] == 4'd0);
            blanco_n[i] = ceros;
        end
    end

    always_ff @(posedge Reloj) begin
        if (!Reinicio_n) begin
            reg_d      <= '0;
            cuenta     <= '0;
            Bcd        <= '0;
            Blanco     <= BLANCO_INI;
            Bcd_valido <= 1'b0;
        end else begin
            Bcd_valido <= 1'b0;
            if (estado == REPOSO && Dato_valido) begin
                reg_d  <= {{NB{1'b0}}, Dato};
                cuenta <= '0;
            end
            if (estado == DESPLAZA) begin
                reg_d  <= {ajustado, reg_d[ANCHO-1:0]} << 1;
                cuenta <= cuenta + 1'b1;
            end
            if (estado == FIN) begin
                Bcd        <= reg_d[NB+ANCHO-1:ANCHO];
                Blanco     <= blanco_n;
                Bcd_valido <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_binario_a_bcd.sv
// tb_binario_a_bcd: directed table-driven bench for binario_a_bcd.
module tb_binario_a_bcd;
    logic        Reloj = 1'b0;
    logic        Reinicio_n = 1'b0;
    logic [7:0]  Dato = '0;
    logic        Dato_valido = 1'b0;
    logic        Listo;
    logic [11:0] Bcd;
    logic [2:0]  Blanco;
    logic        Bcd_valido;

    int n_vec = 0;
    int n_err = 0;
    int ciclo = 0;

    typedef struct {
        logic [7:0]  dato;
        logic [11:0] bcd;
        logic [2:0]  blanco;
    } vector_t;

    vector_t tabla[8];

    binario_a_bcd dut (
        .Reloj      (Reloj),
        .Reinicio_n (Reinicio_n),
        .Dato       (Dato),
        .Dato_valido(Dato_valido),
        .Listo      (Listo),
        .Bcd        (Bcd),
        .Blanco     (Blanco),
        .Bcd_valido (Bcd_valido)
    );

    always #5 Reloj = ~Reloj;
    always @(posedge Reloj) ciclo++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic convertir(input logic [7:0] d, input logic [11:0] eb, input logic [2:0] ebl);
        int n;
        bit ok;
        bit quieto;
        logic [11:0] prev_bcd;
        logic [2:0] prev_bl;
        prev_bcd = Bcd;
        prev_bl = Blanco;
        chk("listo_antes", 32'(Listo), 1);
        Dato = d;
        Dato_valido = 1'b1;
        @(posedge Reloj);
        @(negedge Reloj);
        Dato_valido = 1'b0;
        n = 1;
        ok = 0;
        quieto = 1;
        while (n <= 20 && !ok) begin
            if (Bcd_valido) ok = 1;
            else begin
                if (Bcd !== prev_bcd || Blanco !== prev_bl || Listo !== 1'b0) quieto = 0;
                @(negedge Reloj);
                n++;
            end
        end
        chk($sformatf("latencia_%0d", d), 32'(n - 1), 9);
        chk($sformatf("retenido_%0d", d), 32'(quieto), 1);
        chk($sformatf("bcd_%0d", d), 32'(Bcd), 32'(eb));
        chk($sformatf("blanco_%0d", d), 32'(Blanco), 32'(ebl));
        chk($sformatf("listo_fin_%0d", d), 32'(Listo), 1);
        @(negedge Reloj);
        chk($sformatf("pulso_unico_%0d", d), 32'(Bcd_valido), 0);
    endtask

    initial begin
        tabla[0] = '{8'd0,   12'h000, 3'b110};
        tabla[1] = '{8'd169, 12'h169, 3'b000};
        tabla[2] = '{8'd9,   12'h009, 3'b110};
        tabla[3] = '{8'd255, 12'h255, 3'b000};
        tabla[4] = '{8'd10,  12'h010, 3'b100};
        tabla[5] = '{8'd99,  12'h099, 3'b100};
        tabla[6] = '{8'd100, 12'h100, 3'b000};
        tabla[7] = '{8'd200, 12'h200, 3'b000};

        repeat (2) @(posedge Reloj);
        @(negedge Reloj);
        chk("rst_listo", 32'(Listo), 1);
        chk("rst_bcd", 32'(Bcd), 0);
        chk("rst_blanco", 32'(Blanco), 32'b110);
        chk("rst_valido", 32'(Bcd_valido), 0);
        Reinicio_n = 1'b1;
        @(negedge Reloj);

        for (int i = 0; i < 8; i++) convertir(tabla[i].dato, tabla[i].bcd, tabla[i].blanco);

        // Back-to-back conversions with the request held high.
        begin
            logic [7:0]  datos[3];
            logic [11:0] esperado[3];
            int ultimo_ciclo;
            int n;
            bit estable;
            datos = '{8'd4, 8'd25, 8'd121};
            esperado = '{12'h004, 12'h025, 12'h121};
            Dato = datos[0];
            Dato_valido = 1'b1;
            ultimo_ciclo = 0;
            for (int k = 0; k < 3; k++) begin
                n = 0;
                estable = 1;
                @(negedge Reloj);
                while (!Bcd_valido && n < 30) begin
                    if (k > 0 && Bcd !== esperado[k-1]) estable = 0;
                    @(negedge Reloj);
                    n++;
                end
                chk($sformatf("b2b_bcd_%0d", k), 32'(Bcd), 32'(esperado[k]));
                if (k > 0) begin
                    chk($sformatf("b2b_periodo_%0d", k), 32'(ciclo - ultimo_ciclo), 10);
                    chk($sformatf("b2b_estable_%0d", k), 32'(estable), 1);
                end
                ultimo_ciclo = ciclo;
                if (k < 2) Dato = datos[k+1];
                else Dato_valido = 1'b0;
            end
            @(negedge Reloj);
        end

        // Input changes and requests while busy are ignored.
        begin
            int n;
            Dato = 8'd49;
            Dato_valido = 1'b1;
            @(posedge Reloj);
            @(negedge Reloj);
            Dato_valido = 1'b0;
            @(negedge Reloj);
            Dato = 8'd200;
            Dato_valido = 1'b1;
            repeat (2) @(negedge Reloj);
            Dato_valido = 1'b0;
            n = 0;
            while (!Bcd_valido && n < 20) begin
                @(negedge Reloj);
                n++;
            end
            chk("ignora_bcd", 32'(Bcd), 32'h049);
            chk("ignora_blanco", 32'(Blanco), 32'b100);
            repeat (12) @(negedge Reloj);
            chk("ignora_sin_cola", 32'(Bcd), 32'h049);
        end

        // Reset mid-conversion discards the partial result.
        begin
            bit sin_pulso;
            Dato = 8'd121;
            Dato_valido = 1'b1;
            @(posedge Reloj);
            @(negedge Reloj);
            Dato_valido = 1'b0;
            repeat (3) @(negedge Reloj);
            Reinicio_n = 1'b0;
            @(negedge Reloj);
            Reinicio_n = 1'b1;
            chk("abort_listo", 32'(Listo), 1);
            chk("abort_bcd", 32'(Bcd), 0);
            chk("abort_blanco", 32'(Blanco), 32'b110);
            sin_pulso = 1;
            for (int i = 0; i < 12; i++) begin
                if (Bcd_valido !== 1'b0 || Listo !== 1'b1) sin_pulso = 0;
                @(negedge Reloj);
            end
            chk("abort_sin_pulso", 32'(sin_pulso), 1);
        end

        convertir(8'd121, 12'h121, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/binario_a_bcd.md
# binario_a_bcd

Sequential binary-to-BCD converter (shift-and-add-3) sitting directly upstream of the 7-segment display multiplexer. It accepts an unsigned binary value through a valid/ready handshake and converts it over `ANCHO` iterations. It then presents stable decimal digits plus per-digit leading-zero blank flags. The display stage can therefore show any value, not a fixed lookup set. Outputs change only when a conversion completes, so the display never sees intermediate digits.

## Interface
- `ANCHO`, 8: width of the binary input; one iteration per bit.
- `DIGITOS`, 3: number of BCD digits produced. Requires 10^DIGITOS > 2^ANCHO − 1; violation is an elaboration error.
- `Reloj` input 1: single clock; all state on rising edge.
- `Reinicio_n` input 1: reset, synchronous, active-low.
- `Dato` input ANCHO: unsigned binary value, sampled only on acceptance.
- `Dato_valido` input 1: request to convert `Dato`.
- `Listo` output 1: converter idle; acceptance = `Dato_valido && Listo` at a rising edge.
- `Bcd` output 4·DIGITOS: packed BCD, digit 0 (units) in bits [3:0].
- `Blanco` output DIGITOS: bit i = 1 means digit i is a leading zero to be blanked. Bit 0 is always 0.
- `Bcd_valido` output 1: one-cycle pulse when `Bcd`/`Blanco` have just been updated.

## Operation
- FSM states: REPOSO, DESPLAZA, FIN.
- REPOSO: `Listo`=1. On acceptance, load the shift register with {zeros(4·DIGITOS), Dato} and clear the iteration counter. Go to DESPLAZA.
- DESPLAZA: each cycle, every BCD nibble ≥ 5 gets +3 (all nibbles in parallel). Then the whole register shifts left by 1. Counter increments. After the ANCHO-th iteration, go to FIN.
- FIN: copy the BCD field to `Bcd` and compute `Blanco`. Pulse `Bcd_valido` and return to REPOSO.
- `Blanco` rule: bit i (i ≥ 1) = 1 iff digit i and all higher digits are zero. Value 0 gives all ones except bit 0.
- `Dato` changes and `Dato_valido` while `Listo`=0 are ignored; requests are not queued.
- `Bcd`/`Blanco` hold their previous values throughout a conversion.
- Counter width is clog2(ANCHO+1); no wrap occurs within a conversion.
- Reset values: state REPOSO, `Listo`=1, `Bcd`=0, `Blanco`={1…1,0}, `Bcd_valido`=0, internal register and counter 0.

## Timing
- Acceptance at edge k: DESPLAZA active during edges k+1 … k+ANCHO. Edge k+ANCHO+1 (FIN) updates outputs.
- `Bcd_valido`=1 for exactly the cycle after edge k+ANCHO+1. Latency from acceptance to valid outputs is ANCHO+1 cycles (9 at default).
- `Listo` falls after edge k and rises after edge k+ANCHO+1. The next acceptance is earliest at edge k+ANCHO+2.
- With `Dato_valido` held high, conversions repeat every ANCHO+2 cycles.
- Reset asserted mid-conversion aborts at the next edge. All outputs take reset values and the partial result is discarded. `Bcd_valido` is not pulsed.
- Reset and acceptance at the same edge: reset wins.

## Structure
- Shared package `bcd_pkg`:
  - state enum (REPOSO/DESPLAZA/FIN);
  - BCD nibble typedef;
  - default ANCHO/DIGITOS constants;
  - `Blanco` reset constant.
- Sub-module `suma3_bcd`: combinational 4-bit "add 3 if ≥ 5" cell, instantiated DIGITOS times inside a generate loop.
- Top: FSM, counter, shift register, output registers.

## Test plan
- Reset, then `Dato`=0 -> after 9 cycles `Bcd`=0x000, `Blanco`=3'b110, one `Bcd_valido` pulse.
- `Dato`=169 -> `Bcd`=0x169, `Blanco`=3'b000, valid exactly 9 cycles after acceptance; `Listo` low for 9 cycles.
- `Dato`=9 then `Dato`=255 (max) -> 0x009 with `Blanco`=3'b110, then 0x255 with `Blanco`=3'b000.
- `Dato_valido` held high with `Dato` stepping 4, 25, 121 -> accepts every 10 cycles; results 0x004, 0x025, 0x121 in order. `Bcd` is stable between pulses.
- `Dato` changed from 49 to 200 two cycles after acceptance -> result 0x049; the change is ignored.
- `Reinicio_n` low for one cycle at iteration 4 of converting 121 -> no valid pulse, `Bcd`=0, `Blanco`=3'b110, `Listo`=1 after the reset edge.
